xbar_sched: RTL and testbench

//  - Control-only scheduler for the 2x2 val/rdy crossbar: arbitrates sources s0/s1 onto outputs m0/m1.
//  - Produces per-output source select/valid and per-source ready; the crossbar datapath muxes data on m*_src.
//  - Round-robin fairness per output, packet lock until s*_last, MAX_BEATS watchdog per packet.

---
 rtl/xbar_pkg.sv | 15 +
 rtl/xbar_out_arb.sv | 119 +++++++++++
 rtl/xbar_sched.sv | 85 ++++++++
 tb/tb_xbar_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared types and constants for the 2x2 crossbar scheduler
// Contents: state_t (per-output FSM state), src_t (source id), N_SRC, N_DST.
package xbar_pkg;

  localparam int N_SRC = 2;
  localparam int N_DST = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  typedef logic src_t;

endpackage

// File: rtl/xbar_out_arb.sv
// rtl/xbar_out_arb.sv - one crossbar output: round-robin grant, packet lock, beat watchdog
// Optional feature macro: XBAR_PKT_CNT_EN (adds pkt_cnt output).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req[1:0]      per-source request for this output (val & dst match)
//   last[1:0]     per-source last-beat flag
//   m_rdy         sink ready
//   m_val, m_src  output valid and owning source (forced 0 in reset)
//   rdy[1:0]      per-source ready contribution from this output
//   err           one-cycle pulse after a watchdog release
//   pkt_cnt       saturating packet counter (XBAR_PKT_CNT_EN only)
module xbar_out_arb
  import xbar_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] last,
  input  logic             m_rdy,
  output logic             m_val,
  output src_t             m_src,
  output logic [N_SRC-1:0] rdy,
  output logic             err
`ifdef XBAR_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt
`endif
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] WD_LIM = BW'(MAX_BEATS - 1);

  state_t        state;
  src_t          owner;
  src_t          rr_ptr;
  logic [BW-1:0] beat_cnt;

  src_t gnt;
  logic gnt_vld;
  logic hs;
  logic gnt_last;
  logic wd_hit;
  logic pkt_done;

  always_comb begin
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    if (state == ST_LOCK) begin
      // Owner's beats heading elsewhere drop req here, so the output idles but stays locked.
      gnt     = owner;
      gnt_vld = req[owner];
    end else if (req[0] && req[1]) begin
      gnt     = rr_ptr;
      gnt_vld = 1'b1;
    end else if (req[0]) begin
      gnt     = 1'b0;
      gnt_vld = 1'b1;
    end else if (req[1]) begin
      gnt     = 1'b1;
      gnt_vld = 1'b1;
    end
  end

  assign hs       = gnt_vld & m_rdy;
  assign gnt_last = last[gnt];
  assign wd_hit   = (state == ST_LOCK) && (beat_cnt == WD_LIM);
  assign pkt_done = hs & (gnt_last | wd_hit);

  assign m_val  = rst_n & gnt_vld;
  assign m_src  = rst_n & gnt_vld & gnt;
  assign rdy[0] = rst_n & hs & (gnt == 1'b0);
  assign rdy[1] = rst_n & hs & (gnt == 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (hs) begin
        if (state == ST_IDLE) begin
          if (gnt_last) begin
            rr_ptr <= ~gnt;
          end else begin
            state    <= ST_LOCK;
            owner    <= gnt;
            beat_cnt <= BW'(1);
          end
        end else if (gnt_last || wd_hit) begin
          state    <= ST_IDLE;
          rr_ptr   <= ~owner;
          beat_cnt <= '0;
          err      <= ~gnt_last;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

`ifdef XBAR_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (pkt_done && (pkt_cnt != '1)) begin
      pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end
`else
  wire unused_pkt_done = pkt_done;
`endif

endmodule

// File: rtl/xbar_sched.sv
// rtl/xbar_sched.sv - control-only scheduler for the 2x2 val/rdy crossbar
// Optional feature macro: XBAR_PKT_CNT_EN (adds m0_pkt_cnt, m1_pkt_cnt).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s*_val/s*_dst/s*_last      source beat valid, destination, last beat
//   s*_rdy                     source beat accepted this cycle
//   m*_rdy                     output sink ready
//   m*_val, m*_src             output valid and owning source (data mux select)
//   err[1:0]                   per-output watchdog release pulse
//   m*_pkt_cnt                 per-output packet counters (XBAR_PKT_CNT_EN only)
module xbar_sched
  import xbar_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_val,
  input  logic             s0_dst,
  input  logic             s0_last,
  output logic             s0_rdy,
  input  logic             s1_val,
  input  logic             s1_dst,
  input  logic             s1_last,
  output logic             s1_rdy,
  input  logic             m0_rdy,
  output logic             m0_val,
  output logic             m0_src,
  input  logic             m1_rdy,
  output logic             m1_val,
  output logic             m1_src,
  output logic [1:0]       err
`ifdef XBAR_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0] m0_pkt_cnt,
  output logic [CNT_W-1:0] m1_pkt_cnt
`endif
);

  logic [N_SRC-1:0] req0, req1;
  logic [N_SRC-1:0] rdy0, rdy1;
  logic [N_SRC-1:0] last_v;

  assign req0   = {s1_val & ~s1_dst, s0_val & ~s0_dst};
  assign req1   = {s1_val &  s1_dst, s0_val &  s0_dst};
  assign last_v = {s1_last, s0_last};

  xbar_out_arb #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) u_arb0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req0),
    .last    (last_v),
    .m_rdy   (m0_rdy),
    .m_val   (m0_val),
    .m_src   (m0_src),
    .rdy     (rdy0),
    .err     (err[0])
`ifdef XBAR_PKT_CNT_EN
    ,
    .pkt_cnt (m0_pkt_cnt)
`endif
  );

  xbar_out_arb #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) u_arb1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req1),
    .last    (last_v),
    .m_rdy   (m1_rdy),
    .m_val   (m1_val),
    .m_src   (m1_src),
    .rdy     (rdy1),
    .err     (err[1])
`ifdef XBAR_PKT_CNT_EN
    ,
    .pkt_cnt (m1_pkt_cnt)
`endif
  );

  // A source targets one output at a time, so at most one term is ever set.
  assign s0_rdy = rdy0[0] | rdy1[0];
  assign s1_rdy = rdy0[1] | rdy1[1];

endmodule

// File: tb/tb_xbar_sched.sv
// tb/tb_xbar_sched.sv - directed self-checking bench for xbar_sched
module tb_xbar_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic s0_val, s0_dst, s0_last, s0_rdy;
  logic s1_val, s1_dst, s1_last, s1_rdy;
  logic m0_rdy, m0_val, m0_src;
  logic m1_rdy, m1_val, m1_src;
  logic [1:0] err;
`ifdef XBAR_PKT_CNT_EN
  logic [15:0] m0_pkt_cnt, m1_pkt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xbar_sched #(.MAX_BEATS(16), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s0_val  (s0_val),
    .s0_dst  (s0_dst),
    .s0_last (s0_last),
    .s0_rdy  (s0_rdy),
    .s1_val  (s1_val),
    .s1_dst  (s1_dst),
    .s1_last (s1_last),
    .s1_rdy  (s1_rdy),
    .m0_rdy  (m0_rdy),
    .m0_val  (m0_val),
    .m0_src  (m0_src),
    .m1_rdy  (m1_rdy),
    .m1_val  (m1_val),
    .m1_src  (m1_src),
    .err     (err)
`ifdef XBAR_PKT_CNT_EN
    ,
    .m0_pkt_cnt (m0_pkt_cnt),
    .m1_pkt_cnt (m1_pkt_cnt)
`endif
  );

  task automatic idle_inputs();
    s0_val = 0; s0_dst = 0; s0_last = 0;
    s1_val = 0; s1_dst = 0; s1_last = 0;
    m0_rdy = 0; m1_rdy = 0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    s0_val = 1; s1_val = 1; s1_dst = 1; m0_rdy = 1; m1_rdy = 1;
    #1;
    checks++; if (s0_rdy !== 1'b0) begin errors++; $display("FAIL reset_s0_rdy got %b exp 0", s0_rdy); end
    checks++; if (m0_val !== 1'b0) begin errors++; $display("FAIL reset_m0_val got %b exp 0", m0_val); end
    checks++; if (m1_src !== 1'b0) begin errors++; $display("FAIL reset_m1_src got %b exp 0", m1_src); end
    tick();
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", err); end
    apply_reset();
    #1;
    checks++; if (m0_val !== 1'b0) begin errors++; $display("FAIL idle_m0_val got %b exp 0", m0_val); end
  endtask

  task automatic test_parallel();
    apply_reset();
    s0_val = 1; s0_dst = 0; s0_last = 1;
    s1_val = 1; s1_dst = 1; s1_last = 1;
    m0_rdy = 1; m1_rdy = 1;
    #1;
    checks++; if ({m0_val, m0_src} !== 2'b10) begin errors++; $display("FAIL par_m0 got %b exp 10", {m0_val, m0_src}); end
    checks++; if ({m1_val, m1_src} !== 2'b11) begin errors++; $display("FAIL par_m1 got %b exp 11", {m1_val, m1_src}); end
    checks++; if ({s0_rdy, s1_rdy} !== 2'b11) begin errors++; $display("FAIL par_rdy got %b exp 11", {s0_rdy, s1_rdy}); end
  endtask

  task automatic test_rr();
    logic [2:0] exp_src;
    apply_reset();
    exp_src = 3'b010;
    s0_val = 1; s0_dst = 0; s0_last = 1;
    s1_val = 1; s1_dst = 0; s1_last = 1;
    m0_rdy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (m0_src !== exp_src[c]) begin errors++; $display("FAIL rr_src%0d got %b exp %b", c, m0_src, exp_src[c]); end
      checks++; if ({s0_rdy, s1_rdy} !== {~exp_src[c], exp_src[c]}) begin errors++; $display("FAIL rr_rdy%0d got %b exp %b", c, {s0_rdy, s1_rdy}, {~exp_src[c], exp_src[c]}); end
      tick();
    end
  endtask

  task automatic test_lock();
    apply_reset();
    s0_val = 1; s0_dst = 0; s0_last = 0;
    s1_val = 1; s1_dst = 0; s1_last = 1;
    m0_rdy = 1;
    for (int b = 0; b < 3; b++) begin
      s0_last = (b == 2);
      #1;
      checks++; if ({m0_src, s0_rdy, s1_rdy} !== 3'b010) begin errors++; $display("FAIL lock_beat%0d got %b exp 010", b, {m0_src, s0_rdy, s1_rdy}); end
      tick();
    end
    s0_val = 0;
    #1;
    checks++; if ({m0_val, m0_src, s1_rdy} !== 3'b111) begin errors++; $display("FAIL lock_after got %b exp 111", {m0_val, m0_src, s1_rdy}); end
  endtask

  task automatic test_stall();
    apply_reset();
    s0_val = 1; s0_dst = 0; s0_last = 0;
    m0_rdy = 1;
    tick();
    m0_rdy = 0;
    s1_val = 1; s1_dst = 1; s1_last = 1; m1_rdy = 1;
    #1;
    checks++; if ({m0_val, m0_src, s0_rdy} !== 3'b100) begin errors++; $display("FAIL stall_m0 got %b exp 100", {m0_val, m0_src, s0_rdy}); end
    checks++; if ({m1_val, m1_src, s1_rdy} !== 3'b111) begin errors++; $display("FAIL stall_m1 got %b exp 111", {m1_val, m1_src, s1_rdy}); end
    tick();
    s1_dst = 0; m0_rdy = 1;
    #1;
    checks++; if ({m0_src, s0_rdy, s1_rdy} !== 3'b010) begin errors++; $display("FAIL stall_owner got %b exp 010", {m0_src, s0_rdy, s1_rdy}); end
    s0_val = 0;
    #1;
    checks++; if ({m0_val, s1_rdy} !== 2'b00) begin errors++; $display("FAIL stall_noval got %b exp 00", {m0_val, s1_rdy}); end
    tick();
    #1;
    checks++; if ({m0_val, s1_rdy} !== 2'b00) begin errors++; $display("FAIL stall_held got %b exp 00", {m0_val, s1_rdy}); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    s0_val = 1; s0_dst = 0; s0_last = 0;
    s1_val = 1; s1_dst = 0; s1_last = 1;
    m0_rdy = 1;
    for (int b = 0; b < 16; b++) begin
      #1;
      checks++; if ({m0_src, s0_rdy, err[0]} !== 3'b010) begin errors++; $display("FAIL wd_beat%0d got %b exp 010", b, {m0_src, s0_rdy, err[0]}); end
      tick();
    end
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL wd_err got %b exp 01", err); end
    checks++; if ({m0_src, s1_rdy, s0_rdy} !== 3'b110) begin errors++; $display("FAIL wd_next got %b exp 110", {m0_src, s1_rdy, s0_rdy}); end
`ifdef XBAR_PKT_CNT_EN
    checks++; if (m0_pkt_cnt !== 16'd1) begin errors++; $display("FAIL wd_pkt_cnt got %0d exp 1", m0_pkt_cnt); end
`endif
    tick();
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL wd_err_pulse got %b exp 00", err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    s1_val = 1; s1_dst = 0; s1_last = 0;
    m0_rdy = 1;
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++; if ({m0_val, m0_src, s1_rdy} !== 3'b000) begin errors++; $display("FAIL mid_rst_out got %b exp 000", {m0_val, m0_src, s1_rdy}); end
    tick();
    rst_n = 1;
    s0_val = 1; s0_dst = 0; s0_last = 1;
    s1_last = 1;
    #1;
    checks++; if ({m0_val, m0_src, s0_rdy, s1_rdy} !== 4'b1010) begin errors++; $display("FAIL mid_rst_tie got %b exp 1010", {m0_val, m0_src, s0_rdy, s1_rdy}); end
`ifdef XBAR_PKT_CNT_EN
    checks++; if (m0_pkt_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt0 got %0d exp 0", m0_pkt_cnt); end
    tick();
    checks++; if (m0_pkt_cnt !== 16'd1) begin errors++; $display("FAIL mid_rst_cnt1 got %0d exp 1", m0_pkt_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_rr();
    test_lock();
    test_stall();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
